// File: rtl/vga_sync.sv
// vga_sync: 640x480@60 raster timing generator with pixel-rate divider.
// Sync/videoOn are registered one clk behind x/y to line up with registered rgb.
module vga_sync #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter int CLK_DIV   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       videoOn,
    output logic       hsync,
    output logic       vsync,
    output logic       pixel_tick,
    output logic       frame_start
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0]       H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]       V_LAST   = 10'(V_TOTAL - 1);

    // 11-bit decode constants so a 1024-wide total cannot overflow
    localparam logic [10:0] H_VIS  = 11'(H_VISIBLE);
    localparam logic [10:0] V_VIS  = 11'(V_VISIBLE);
    localparam logic [10:0] HS_BEG = 11'(H_VISIBLE + H_FRONT);
    localparam logic [10:0] HS_END = 11'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [10:0] VS_BEG = 11'(V_VISIBLE + V_FRONT);
    localparam logic [10:0] VS_END = 11'(V_VISIBLE + V_FRONT + V_SYNC);

    if (H_TOTAL > 1024 || V_TOTAL > 1024 || CLK_DIV < 1) begin : g_bad_params
        $error("vga_sync: totals must be <= 1024 and CLK_DIV >= 1");
    end

    logic [DIV_W-1:0] div_q, div_d;
    logic [9:0]       x_q, x_d;
    logic [9:0]       y_q, y_d;
    logic             von_q, von_d;
    logic             hs_q, hs_d;
    logic             vs_q, vs_d;
    logic             fs_q, fs_d;
    logic [10:0]      xe, ye;

    assign pixel_tick = (div_q == DIV_LAST);
    assign xe = {1'b0, x_q};
    assign ye = {1'b0, y_q};

    always_comb begin
        div_d = pixel_tick ? '0 : div_q + 1'b1;
        x_d   = x_q;
        y_d   = y_q;
        fs_d  = 1'b0;
        if (pixel_tick) begin
            if (x_q >= H_LAST) begin
                x_d = '0;
                if (y_q >= V_LAST) begin
                    y_d  = '0;
                    fs_d = 1'b1;
                end else begin
                    y_d = y_q + 10'd1;
                end
            end else begin
                x_d = x_q + 10'd1;
            end
        end
        von_d = (xe < H_VIS) && (ye < V_VIS);
        hs_d  = !((xe >= HS_BEG) && (xe < HS_END));
        vs_d  = !((ye >= VS_BEG) && (ye < VS_END));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= '0;
            x_q   <= '0;
            y_q   <= '0;
            von_q <= 1'b0;
            hs_q  <= 1'b1;
            vs_q  <= 1'b1;
            fs_q  <= 1'b0;
        end else begin
            div_q <= div_d;
            x_q   <= x_d;
            y_q   <= y_d;
            von_q <= von_d;
            hs_q  <= hs_d;
            vs_q  <= vs_d;
            fs_q  <= fs_d;
        end
    end

    assign x           = x_q;
    assign y           = y_q;
    assign videoOn     = von_q;
    assign hsync       = hs_q;
    assign vsync       = vs_q;
    assign frame_start = fs_q;

endmodule
